vrf_read_responder: RTL and testbench
=====================================

# vrf_read_responder

- Serves the bank end of the VRF read-request channel.
- Accepts one `VRFReadRequest` per cycle (vs, readSource, offset, instructionIndex) via ready/valid.
- Issues the read to a synchronous fixed-latency VRF bank SRAM and returns the data tagged with readSource and instructionIndex.
- Uses credit-guarded response buffering, so downstream backpressure never drops or reorders data.

## Interface
Parameters:
- `DATA_W`, 32, VRF read data width.
- `READ_LATENCY`, 2, SRAM cycles from `sram_en` to valid `sram_rdata`; legal values 1..4.
- `FIFO_DEPTH`, 4, response buffer entries; power of two, at least `READ_LATENCY+1` for full throughput.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `io_req_ready`  out  1  request may be accepted this cycle.
- `io_req_valid`  in  1  request present.
- `io_req_bits_vs`  in  5  vector register.
- `io_req_bits_readSource`  in  2  requester tag.
- `io_req_bits_offset`  in  3  row within register group.
- `io_req_bits_instructionIndex`  in  3  owning instruction.
- `sram_en`  out  1  bank read enable.
- `sram_addr`  out  8  `{vs, offset}`.
- `sram_rdata`  in  DATA_W  read data, valid `READ_LATENCY` cycles after `sram_en`.
- `io_resp_ready`  in  1  consumer accepts.
- `io_resp_valid`  out  1  response present.
- `io_resp_bits_data`  out  DATA_W  read data.
- `io_resp_bits_readSource`  out  2  echoed tag.
- `io_resp_bits_instructionIndex`  out  3  echoed tag.
- `io_busy`  out  1  any request in flight or buffered.

## Operation
- **Credit counter `occ`.** Width `clog2(FIFO_DEPTH)+1`. Counts requests accepted but not yet delivered.
  - `io_req_ready = occ < FIFO_DEPTH`.
  - Request fire: `+1`. Response fire: `-1`. Both in the same cycle: unchanged.
- **Issue.**
  - `sram_en = io_req_valid & io_req_ready`, combinational.
  - `sram_addr = {vs, offset}`, combinational.
  - `sram_addr` is don't-care when `sram_en` is 0 but must not be X after reset.
- **Tag pipeline.** `READ_LATENCY`-stage shift register of `{valid, readSource, instructionIndex}`, advanced every cycle unconditionally.
  - Stage-last valid means `sram_rdata` is valid this cycle.
  - On that cycle, `{sram_rdata, tags}` is pushed into the FIFO.
- **FIFO behaviour.**
  - Push never finds the FIFO full; the credit counter guarantees this. An assertion checks it.
  - Pop on `io_resp_valid & io_resp_ready`.
  - Head drives `io_resp_*`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Ordering.** Responses leave strictly in request order.
- **`io_busy`.** `occ != 0`.
- **Reset values.**
  - `occ`, all pipeline valids and the FIFO pointers clear to 0.
  - `io_req_ready` = 1, `io_resp_valid` = 0, `sram_en` = 0, `io_busy` = 0.
  - Response data/tag outputs = 0.
- **Reset mid-operation.** All in-flight and buffered requests are discarded silently. SRAM data arriving after reset deasserts is ignored, because the pipeline valids are clear.

## Timing
- **Latency.** Request accepted at cycle t drives `io_resp_valid` at t+`READ_LATENCY`+1. There is no bypass of the FIFO.
- **Throughput.** One request per cycle is sustained while `io_resp_ready` = 1 and `FIFO_DEPTH >= READ_LATENCY+1`.
- **Backpressure.** With `io_resp_ready` held low, exactly `FIFO_DEPTH` requests are accepted, then `io_req_ready` drops the cycle after the last accept.
- **Ready recovery.** A response fire while `occ == FIFO_DEPTH` raises `io_req_ready` the next cycle. It is not raised combinationally, so there is no ready-to-ready path.
- **Handshake stability.**
  - `io_resp_valid` and the response bits stay stable until fired.
  - `io_req_ready` does not depend on `io_req_valid`.

## Structure
- **Shared package `vrf_pkg`.** Holds:
  - `vrf_read_req_t` (vs 5, readSource 2, offset 3, instructionIndex 3);
  - `vrf_read_tag_t` (readSource, instructionIndex);
  - localparam `VRF_ADDR_W = 8`.
- **Sub-module `vrf_resp_fifo`.** Parameterised by width and depth, with push/pop/head and full/empty flags. It is instantiated once. The credit counter and tag pipeline live in the top.

## Test plan
- **Single read.** `READ_LATENCY=2`, request vs=3, offset=5, readSource=2, instructionIndex=6; SRAM returns 0xDEADBEEF. Expect `sram_addr=0x1D` at t, and response valid at t+3 with data 0xDEADBEEF, readSource 2, index 6.
- **Streaming.** 16 back-to-back requests with `io_resp_ready` = 1. Expect 16 in-order responses on consecutive cycles and `io_req_ready` never low.
- **Backpressure.** `io_resp_ready` = 0, offer 6 requests. Expect exactly 4 accepted, `io_req_ready` = 0 afterwards, and `io_busy` = 1. Raising ready drains 4 in order, then the remaining 2 are accepted.
- **Simultaneous fire at full.** Hold `occ` = 4; pop one while a request is valid. Expect `occ` stays 4 for that cycle and the accept occurs on the following cycle.
- **Reset mid-flight.** Assert reset with 2 reads in the pipeline and 1 buffered. Expect all outputs at reset values, no responses produced from stale `sram_rdata`, and the next request served normally.
- **Wrap-around.** 3·`FIFO_DEPTH`+1 requests with random `io_resp_ready`. Scoreboard: zero loss, zero reorder, no FIFO overflow assertion.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared types for the VRF read path.
//   vrf_read_req_t : one read request as presented on the request channel.
//   vrf_read_tag_t : the tags echoed back with the read data.
//   VRF_ADDR_W     : bank SRAM address width ({vs, offset}).
package vrf_pkg;

  localparam int unsigned VRF_ADDR_W = 8;

  typedef struct packed {
    logic [4:0] vs;
    logic [1:0] read_source;
    logic [2:0] offset;
    logic [2:0] instruction_index;
  } vrf_read_req_t;

  typedef struct packed {
    logic [1:0] read_source;
    logic [2:0] instruction_index;
  } vrf_read_tag_t;

  localparam int unsigned VRF_TAG_W = $bits(vrf_read_tag_t);

endpackage

// File: rtl/vrf_resp_fifo.sv
// Response buffer for the VRF read responder.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   push_i, wdata_i    write one entry (ignored when full)
//   pop_i              drop the head entry (ignored when empty)
//   rdata_o            head entry, driven to 0 while empty
//   full_o, empty_o    occupancy flags
module vrf_resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/vrf_read_responder.sv
// Bank-side responder for the VRF read-request channel.
// Accepts one request per cycle, issues it to a fixed-latency bank SRAM and returns
// the data tagged with readSource/instructionIndex, strictly in request order.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   io_req_*                     request channel (ready/valid)
//   sram_en, sram_addr           bank read port, sram_rdata valid READ_LATENCY cycles later
//   io_resp_*                    response channel (ready/valid)
//   io_busy                      any request accepted but not yet delivered
module vrf_read_responder
  import vrf_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  io_req_ready,
  input  logic                  io_req_valid,
  input  logic [4:0]            io_req_bits_vs,
  input  logic [1:0]            io_req_bits_readSource,
  input  logic [2:0]            io_req_bits_offset,
  input  logic [2:0]            io_req_bits_instructionIndex,
  output logic                  sram_en,
  output logic [VRF_ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0]     sram_rdata,
  input  logic                  io_resp_ready,
  output logic                  io_resp_valid,
  output logic [DATA_W-1:0]     io_resp_bits_data,
  output logic [1:0]            io_resp_bits_readSource,
  output logic [2:0]            io_resp_bits_instructionIndex,
  output logic                  io_busy
);

  localparam int unsigned OccW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FifoW = DATA_W + VRF_TAG_W;
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

  vrf_read_req_t req;
  logic          req_fire, resp_fire;

  assign req = '{vs:                io_req_bits_vs,
                 read_source:       io_req_bits_readSource,
                 offset:            io_req_bits_offset,
                 instruction_index: io_req_bits_instructionIndex};

  // Credit counter: every accepted request owns a FIFO slot until delivered, so a
  // push from the tag pipeline can never find the buffer full.
  logic [OccW-1:0] occ_q, occ_d;

  assign io_req_ready = (occ_q < OccFull);
  assign req_fire     = io_req_valid && io_req_ready;
  assign resp_fire    = io_resp_valid && io_resp_ready;
  assign io_busy      = (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    unique case ({req_fire, resp_fire})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  assign sram_en   = req_fire;
  assign sram_addr = {req.vs, req.offset};

  // Tag pipeline mirrors the SRAM latency; the last stage marks valid read data.
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  vrf_read_tag_t           pt_q [READ_LATENCY];
  vrf_read_tag_t           pt_d [READ_LATENCY];

  always_comb begin
    pv_d[0] = req_fire;
    pt_d[0] = '{read_source: req.read_source, instruction_index: req.instruction_index};
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
      pv_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pt_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      pv_q  <= pv_d;
      for (int i = 0; i < READ_LATENCY; i++) pt_q[i] <= pt_d[i];
    end
  end

  logic             fifo_push, fifo_full, fifo_empty;
  logic [FifoW-1:0] fifo_wdata, fifo_rdata;
  vrf_read_tag_t    head_tag;

  assign fifo_push  = pv_q[READ_LATENCY-1];
  assign fifo_wdata = {sram_rdata, pt_q[READ_LATENCY-1]};

  vrf_resp_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (resp_fire),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign io_resp_valid                 = !fifo_empty;
  assign {io_resp_bits_data, head_tag} = fifo_rdata;
  assign io_resp_bits_readSource       = head_tag.read_source;
  assign io_resp_bits_instructionIndex = head_tag.instruction_index;

  push_never_full_a: assert property (@(posedge clock) disable iff (reset)
                                      fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_vrf_read_responder.sv
// Self-checking bench for vrf_read_responder with a latency-accurate SRAM model and a
// transaction-level reference: a queue of accepted requests, each due L+1 cycles later.
module tb_vrf_read_responder;

  localparam int unsigned W = 32;
  localparam int unsigned L = 2;
  localparam int unsigned D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         io_req_ready, io_req_valid;
  logic [4:0]   req_vs;
  logic [1:0]   req_rs;
  logic [2:0]   req_off, req_ii;
  logic         sram_en;
  logic [7:0]   sram_addr;
  logic [W-1:0] sram_rdata;
  logic         io_resp_ready, io_resp_valid;
  logic [W-1:0] resp_data;
  logic [1:0]   resp_rs;
  logic [2:0]   resp_ii;
  logic         io_busy;

  always #5 clock = ~clock;

  vrf_read_responder #(
    .DATA_W       (W),
    .READ_LATENCY (L),
    .FIFO_DEPTH   (D)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_req_ready                  (io_req_ready),
    .io_req_valid                  (io_req_valid),
    .io_req_bits_vs                (req_vs),
    .io_req_bits_readSource        (req_rs),
    .io_req_bits_offset            (req_off),
    .io_req_bits_instructionIndex  (req_ii),
    .sram_en                       (sram_en),
    .sram_addr                     (sram_addr),
    .sram_rdata                    (sram_rdata),
    .io_resp_ready                 (io_resp_ready),
    .io_resp_valid                 (io_resp_valid),
    .io_resp_bits_data             (resp_data),
    .io_resp_bits_readSource       (resp_rs),
    .io_resp_bits_instructionIndex (resp_ii),
    .io_busy                       (io_busy)
  );

  // Bank SRAM: fixed latency, never reset, drives junk when not reading.
  logic [W-1:0] mem [256];
  logic [W-1:0] sdl [L];
  always @(posedge clock) begin
    sdl[0] <= sram_en ? mem[sram_addr] : W'($urandom);
    for (int i = 1; i < L; i++) sdl[i] <= sdl[i-1];
  end
  assign sram_rdata = sdl[L-1];

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   rs;
    logic [2:0]   ii;
    int           t;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   rand_rr = 0;
  bit   m_acc, m_ev;
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cycle <= cycle + 1;

  // Reference: a request is accepted whenever fewer than D are outstanding; each
  // response becomes visible exactly L+1 cycles after its accept, in order.
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
    end else begin
      m_acc = io_req_valid && (q.size() < D);
      m_ev  = (q.size() != 0) && (q[0].t + L + 1 <= cycle);
      chk("req_ready", 64'(io_req_ready), 64'(q.size() < D));
      chk("busy", 64'(io_busy), 64'(q.size() != 0));
      chk("resp_valid", 64'(io_resp_valid), 64'(m_ev));
      chk("sram_en", 64'(sram_en), 64'(m_acc));
      if (m_acc) chk("sram_addr", 64'(sram_addr), 64'({req_vs, req_off}));
      if (m_ev) begin
        chk("resp_data", 64'(resp_data), 64'(q[0].data));
        chk("resp_rs", 64'(resp_rs), 64'(q[0].rs));
        chk("resp_ii", 64'(resp_ii), 64'(q[0].ii));
        if (io_resp_ready) void'(q.pop_front());
      end
      if (m_acc) begin
        e.data = mem[{req_vs, req_off}];
        e.rs   = req_rs;
        e.ii   = req_ii;
        e.t    = cycle;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_rr) io_resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [4:0] vs, input logic [2:0] off, input logic [1:0] rs,
                      input logic [2:0] ii);
    bit done = 0;
    req_vs = vs; req_off = off; req_rs = rs; req_ii = ii;
    io_req_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      done = io_req_ready;
      step();
    end
    io_req_valid = 1'b0;
    chk("send_accept", 64'(done), 64'(1));
  endtask

  task automatic send_rand();
    send(5'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    io_resp_ready = 1'b1;
    for (int k = 0; k < 200 && q.size() != 0; k++) step();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 64'(io_req_ready), 64'(1));
    chk("rst_resp_valid", 64'(io_resp_valid), 64'(0));
    chk("rst_sram_en", 64'(sram_en), 64'(0));
    chk("rst_busy", 64'(io_busy), 64'(0));
    chk("rst_data", 64'(resp_data), 64'(0));
    chk("rst_rs", 64'(resp_rs), 64'(0));
    chk("rst_ii", 64'(resp_ii), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    io_req_valid = 1'b0;
    io_resp_ready = 1'b0;
    req_vs = '0; req_off = '0; req_rs = '0; req_ii = '0;
    repeat (2) @(negedge clock);
    chk_reset_outputs();
    @(posedge clock);
    #1 reset = 1'b0;

    // Single read: addr {3,5} = 0x1D, response visible exactly 3 cycles after accept.
    mem[8'h1D] = 32'hDEADBEEF;
    io_resp_ready = 1'b1;
    req_vs = 5'd3; req_off = 3'd5;
    @(negedge clock);
    chk("single_addr", 64'(sram_addr), 64'h1D);
    step();
    send(5'd3, 3'd5, 2'd2, 3'd6);
    repeat (2) @(negedge clock);
    chk("single_early", 64'(io_resp_valid), 64'(0));
    @(negedge clock);
    chk("single_valid", 64'(io_resp_valid), 64'(1));
    chk("single_data", 64'(resp_data), 64'hDEADBEEF);
    chk("single_rs", 64'(resp_rs), 64'(2));
    chk("single_ii", 64'(resp_ii), 64'(6));
    step();
    drain();

    // Streaming: 16 back-to-back requests.
    for (int i = 0; i < 16; i++) send_rand();
    drain();

    // Backpressure: 4 accepted, 5th held off until the consumer drains.
    io_resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand();
    req_vs = 5'd9; req_off = 3'd1; req_rs = 2'd1; req_ii = 3'd4;
    io_req_valid = 1'b1;
    idle(5);
    @(negedge clock);
    chk("bp_ready_low", 64'(io_req_ready), 64'(0));
    chk("bp_busy", 64'(io_busy), 64'(1));
    step();
    io_resp_ready = 1'b1;
    send(5'd9, 3'd1, 2'd1, 3'd4);
    send_rand();
    drain();

    // Pop at full with a request waiting: accept lands on the following cycle.
    io_resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand();
    idle(4);
    req_vs = 5'd17; req_off = 3'd7; req_rs = 2'd3; req_ii = 3'd2;
    io_req_valid = 1'b1;
    io_resp_ready = 1'b1;
    @(negedge clock);
    chk("full_pop_ready", 64'(io_req_ready), 64'(0));
    chk("full_pop_valid", 64'(io_resp_valid), 64'(1));
    step();
    io_resp_ready = 1'b0;
    @(negedge clock);
    chk("full_recover", 64'(io_req_ready), 64'(1));
    step();
    io_req_valid = 1'b0;
    @(negedge clock);
    chk("full_again", 64'(io_req_ready), 64'(0));
    step();
    drain();

    // Reset with one response buffered and two reads in the SRAM pipeline.
    io_resp_ready = 1'b0;
    send_rand();
    idle(3);
    send_rand();
    send_rand();
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    idle(2);
    reset = 1'b0;
    io_resp_ready = 1'b1;
    idle(5);
    send(5'd30, 3'd2, 2'd1, 3'd5);
    drain();

    // Wrap-around under random consumer backpressure.
    rand_rr = 1;
    for (int i = 0; i < 3 * D + 1; i++) send_rand();
    idle(10);
    rand_rr = 0;
    drain();

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
